// File: rtl/serial_adder_sub_n.sv
// rtl/serial_adder_sub_n.sv - bit-serial adder/subtractor, one full-add cell per clock
// Operands shift out LSB first; carry lives in a flop and the result shifts in from the MSB side.
module serial_adder_sub_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_bitcnt;

  logic             w_s;
  logic             w_carry_next;
  logic             w_last;
  logic [WIDTH-1:0] w_result_next;

  assign w_s          = r_op_a[0] ^ r_op_b[0] ^ r_carry;
  assign w_carry_next = (r_op_a[0] & r_op_b[0]) | (r_op_a[0] & r_carry) | (r_op_b[0] & r_carry);
  assign w_last       = (r_bitcnt == CNT_W'(WIDTH - 1));

  // A one-bit result has no upper bits to shift down.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign w_result_next = w_s;
    end else begin : g_res_wn
      assign w_result_next = {w_s, r_result[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_bitcnt <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1, so cin is replaced by a forced carry.
            r_state  <= S_RUN;
            r_busy   <= 1'b1;
            r_op_a   <= a;
            r_op_b   <= sub ? ~b : b;
            r_carry  <= sub ? 1'b1 : cin;
            r_result <= '0;
            r_bitcnt <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_carry  <= w_carry_next;
          r_result <= w_result_next;
          r_op_a   <= r_op_a >> 1;
          r_op_b   <= r_op_b >> 1;
          r_bitcnt <= r_bitcnt + CNT_W'(1);
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_sum   <= w_result_next;
            r_cout  <= w_carry_next;
            r_ovf   <= r_carry ^ w_carry_next;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder_sub_n.sv
// tb/tb_serial_adder_sub_n.sv - scoreboard bench for serial_adder_sub_n at WIDTH=8 and WIDTH=1
module tb_serial_adder_sub_n;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  logic start1 = 1'b0, sub1 = 1'b0, cin1 = 1'b0, a1 = 1'b0, b1 = 1'b0;
  logic busy1, done1, sum1, cout1, ovf1;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [9:0] q8[$];
  int         qc8[$];
  logic [9:0] q1[$];
  int         qc1[$];
  logic [9:0] hold8 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_sub_n #(.WIDTH(W)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  serial_adder_sub_n #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: true integer arithmetic, then reduced to w bits; returns {ovf, cout, sum[7:0]}.
  function automatic logic [9:0] model(input int w, input logic s, input logic [7:0] ai,
                                       input logic [7:0] bi, input logic ci);
    longint m, ua, ub, sa, sb, u, r, sm;
    logic co, ov;
    m  = longint'(1) << w;
    ua = longint'(ai) % m;
    ub = longint'(bi) % m;
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (s) begin
      u  = ua - ub;
      r  = sa - sb;
      co = (ua >= ub);
    end else begin
      u  = ua + ub + longint'(ci);
      r  = sa + sb + longint'(ci);
      co = (u >= m);
    end
    ov = (r < -(m / 2)) || (r >= m / 2);
    sm = ((u % m) + m) % m;
    return {ov, co, sm[7:0]};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      hold8 = '0;
    end else begin
      chk("busy_done_excl", busy & done, 0);
      if (done) begin
        if (q8.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          hold8 = q8.pop_front();
          chk("result8", {ovf, cout, sum}, hold8);
          chk("done_cycle8", cyc, qc8.pop_front());
        end
      end else begin
        chk("hold8", {ovf, cout, sum}, hold8);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done1) begin
      if (q1.size() == 0) begin
        chk("unexpected_done1", 1, 0);
      end else begin
        logic [9:0] e;
        e = q1.pop_front();
        chk("result1", {ovf1, cout1, sum1}, {e[9:8], e[0]});
        chk("done_cycle1", cyc, qc1.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  task automatic do_op(input logic s, input logic [7:0] ai, input logic [7:0] bi, input logic ci);
    wait_idle();
    start = 1'b1; sub = s; a = ai; b = bi; cin = ci;
    q8.push_back(model(W, s, ai, bi, ci));
    qc8.push_back(cyc + 1 + W);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    chk("busy_after_start", busy, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((q8.size() != 0 || q1.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q8.size() + q1.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, ovf, cout, sum}, 0);
    chk("reset_outputs1", {busy1, done1, ovf1, cout1, sum1}, 0);
    rst_n = 1'b1;

    do_op(1'b0, 8'h5A, 8'h3C, 1'b0);
    do_op(1'b0, 8'hFF, 8'h01, 1'b0);
    do_op(1'b0, 8'hFF, 8'h01, 1'b1);
    do_op(1'b1, 8'h10, 8'h20, 1'b1);
    do_op(1'b1, 8'h80, 8'h01, 1'b0);

    // start pulsed mid-RUN must be ignored
    do_op(1'b0, 8'h33, 8'h44, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; a = 8'hEE; b = 8'hDD; sub = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;

    // start held high through DONE: second op accepted with no IDLE gap
    begin
      int c0, n;
      wait_idle();
      c0 = cyc;
      start = 1'b1; sub = 1'b0; a = 8'h7F; b = 8'h01; cin = 1'b0;
      q8.push_back(model(W, 1'b0, 8'h7F, 8'h01, 1'b0));
      qc8.push_back(c0 + 1 + W);
      @(posedge clk);
      #1;
      sub = 1'b1; a = 8'h05; b = 8'h09; cin = 1'b1;
      q8.push_back(model(W, 1'b1, 8'h05, 8'h09, 1'b1));
      qc8.push_back(c0 + 2 * (1 + W));
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done && n < 30);
      chk("b2b_done_seen", done, 1);
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("b2b_no_gap", busy, 1);
    end

    for (int i = 0; i < 40; i++) begin
      do_op(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // reset for one cycle while bit 4 is pending
    do_op(1'b0, 8'hA5, 8'h5A, 1'b1);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    void'(q8.pop_back());
    void'(qc8.pop_back());
    #1;
    chk("midrun_reset_outputs", {busy, done, ovf, cout, sum}, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    chk("after_reset_idle", {busy, done, ovf, cout, sum}, 0);

    do_op(1'b0, 8'h01, 8'h02, 1'b0);

    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      int n;
      v = 4'(i);
      n = 0;
      @(negedge clk);
      while (busy1 && n < 10) begin
        @(negedge clk);
        n++;
      end
      start1 = 1'b1; sub1 = v[3]; a1 = v[2]; b1 = v[1]; cin1 = v[0];
      q1.push_back(model(1, v[3], {7'd0, v[2]}, {7'd0, v[1]}, v[0]));
      qc1.push_back(cyc + 2);
      @(posedge clk);
      #1;
      start1 = 1'b0;
      chk("busy1_after_start", busy1, 1);
    end

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
